// File: rtl/muldiv_pkg.sv
// Shared state encoding and select constants for the MULT/DIV sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MULT_INIT = 3'd1,
    ST_MULT_RUN  = 3'd2,
    ST_DIV_INIT  = 3'd3,
    ST_DIV_RUN   = 3'd4,
    ST_WB        = 3'd5,
    ST_DZ        = 3'd6
  } state_t;

  localparam logic HILO_SEL_MULT = 1'b0;
  localparam logic HILO_SEL_DIV  = 1'b1;

  localparam int DEF_TIMEOUT_CYCLES = 40;

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer for the mult/div units and the HI/LO pair; all outputs registered.
// Define MULDIV_TIMEOUT_EN to abort a RUN state after TIMEOUT_CYCLES cycles.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 6
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] divisor,
  input  logic        mult_stop,
  input  logic        div_stop,
  output logic        mult_init,
  output logic        div_init,
  output logic        hilo_sel,
  output logic        high_load,
  output logic        low_load,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        timeout
);

  state_t state, state_n;

`ifdef MULDIV_TIMEOUT_EN
  logic [CNT_W-1:0] run_cnt;
  logic             run_expired;
  logic             timeout_n;

  // run_cnt holds the number of RUN cycles already completed in this run.
  assign run_expired = (run_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    state_n = state;
`ifdef MULDIV_TIMEOUT_EN
    timeout_n = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start_mult)               state_n = ST_MULT_INIT;
        else if (start_div)           state_n = (divisor == '0) ? ST_DZ : ST_DIV_INIT;
      end
      ST_MULT_INIT:                   state_n = ST_MULT_RUN;
      ST_DIV_INIT:                    state_n = ST_DIV_RUN;
      ST_MULT_RUN: begin
        if (mult_stop)                state_n = ST_WB;
`ifdef MULDIV_TIMEOUT_EN
        else if (run_expired) begin
          state_n   = ST_IDLE;
          timeout_n = 1'b1;
        end
`endif
      end
      ST_DIV_RUN: begin
        if (div_stop)                 state_n = ST_WB;
`ifdef MULDIV_TIMEOUT_EN
        else if (run_expired) begin
          state_n   = ST_IDLE;
          timeout_n = 1'b1;
        end
`endif
      end
      ST_WB, ST_DZ:                   state_n = ST_IDLE;
      default:                        state_n = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered, so they line up with it.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      mult_init <= 1'b0;
      div_init  <= 1'b0;
      hilo_sel  <= 1'b0;
      high_load <= 1'b0;
      low_load  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      state     <= state_n;
      mult_init <= (state_n == ST_MULT_INIT);
      div_init  <= (state_n == ST_DIV_INIT);
      high_load <= (state_n == ST_WB);
      low_load  <= (state_n == ST_WB);
      done      <= (state_n == ST_WB);
      div_zero  <= (state_n == ST_DZ);
      busy      <= (state_n != ST_IDLE);
      if (state_n == ST_MULT_INIT)     hilo_sel <= HILO_SEL_MULT;
      else if (state_n == ST_DIV_INIT) hilo_sel <= HILO_SEL_DIV;
    end
  end

`ifdef MULDIV_TIMEOUT_EN
  // Counter is zero on entry to a RUN state and saturates instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= timeout_n;
      if (state == ST_MULT_RUN || state == ST_DIV_RUN) begin
        if (run_cnt != '1) run_cnt <= run_cnt + 1'b1;
      end else begin
        run_cnt <= '0;
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: the driver predicts pulse cycles from the
// latency rules, a negedge monitor pops and compares every observed pulse.
`timescale 1ns/1ps
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_mult = 1'b0, start_div = 1'b0;
  logic [31:0] divisor = '0;
  logic        mult_stop = 1'b0, div_stop = 1'b0;
  logic        mult_init, div_init, hilo_sel, high_load, low_load;
  logic        busy, done, div_zero, timeout;

  localparam int TMO_P = 8;

`ifdef MULDIV_TIMEOUT_EN
  localparam int TMO = TMO_P;
`else
  localparam int TMO = 1_000_000;
`endif

  muldiv_ctrl #(.TIMEOUT_CYCLES(TMO_P)) dut (
    .clk(clk), .reset(reset),
    .start_mult(start_mult), .start_div(start_div), .divisor(divisor),
    .mult_stop(mult_stop), .div_stop(div_stop),
    .mult_init(mult_init), .div_init(div_init), .hilo_sel(hilo_sel),
    .high_load(high_load), .low_load(low_load), .busy(busy),
    .done(done), .div_zero(div_zero), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [5:0] v;
  } ev_t;

  // init events: {3'b0, mult_init, div_init, hilo_sel}
  // resp events: {done, high_load, low_load, div_zero, timeout, hilo_sel}
  ev_t init_q[$];
  ev_t resp_q[$];
  logic model_sel = 1'b0;

  int tests = 0;
  int failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse the DUT shows must match the oldest expectation.
  always @(negedge clk) begin
    ev_t e;
    logic [5:0] iv, rv;
    if (reset) begin
      iv = {3'b000, mult_init, div_init, hilo_sel};
      rv = {done, high_load, low_load, div_zero, timeout, hilo_sel};
      if (mult_init || div_init) begin
        if (init_q.size() == 0) check("init_unexpected", {cyc, 26'd0, iv}, 64'd0);
        else begin
          e = init_q.pop_front();
          check("init", {cyc, 26'd0, iv}, {e.cyc, 26'd0, e.v});
        end
      end
      if (done || high_load || low_load || div_zero || timeout) begin
        if (resp_q.size() == 0) check("resp_unexpected", {cyc, 26'd0, rv}, 64'd0);
        else begin
          e = resp_q.pop_front();
          check("resp", {cyc, 26'd0, rv}, {e.cyc, 26'd0, e.v});
        end
      end
    end
  end

  function automatic logic rnd(input bit en);
    return en ? logic'($urandom_range(0, 1)) : 1'b0;
  endfunction

  // Called at the negedge of the cycle the sequencer should be back in IDLE.
  task automatic idle_check(input string name);
    start_mult = 1'b0;
    start_div  = 1'b0;
    mult_stop  = 1'b0;
    div_stop   = 1'b0;
    check(name, {63'd0, busy}, 64'd0);
  endtask

  // One transaction issued at the current negedge (cycle c). The stop for a
  // run arrives in the d-th RUN cycle (cycle c+1+d); done follows one cycle later.
  task automatic txn(input bit op_div, input logic [31:0] dv, input int d,
                     input bit both, input bit noise);
    int  c;
    bit  is_mult, timed_out;
    c = cyc;
    is_mult   = !op_div || both;
    timed_out = 1'b0;
    start_mult = !op_div || both;
    start_div  = op_div || both;
    divisor    = dv;
    if (is_mult) begin
      model_sel = 1'b0;
      init_q.push_back('{c + 1, 6'b000_100});
    end else if (dv == 0) begin
      resp_q.push_back('{c + 1, {5'b00010, model_sel}});
    end else begin
      model_sel = 1'b1;
      init_q.push_back('{c + 1, 6'b000_011});
    end

    @(negedge clk);  // INIT or DZ cycle: starts and stops here are ignored
    start_mult = rnd(noise);
    start_div  = rnd(noise);
    divisor    = $urandom;
    mult_stop  = rnd(1'b1);
    div_stop   = rnd(1'b1);
    if (!is_mult && dv == 0) begin
      @(negedge clk);
      idle_check("busy_after_dz");
      return;
    end

    for (int j = 1; j <= d; j++) begin
      @(negedge clk);  // RUN cycle c+1+j
      if (j == 1) check("busy_run", {63'd0, busy}, 64'd1);
      start_mult = rnd(noise);
      start_div  = rnd(noise);
      if (noise && j == 4) start_div = 1'b1;
      if (is_mult) begin
        mult_stop = (j == d);
        div_stop  = (noise && j == 4) ? 1'b1 : rnd(noise);
      end else begin
        div_stop  = (j == d);
        mult_stop = rnd(noise);
      end
      if (j == d) begin
        resp_q.push_back('{c + 2 + j, {5'b11100, model_sel}});
      end else if (j == TMO) begin
        resp_q.push_back('{c + 2 + j, {5'b00001, model_sel}});
        timed_out = 1'b1;
        break;
      end
    end

    @(negedge clk);  // WB cycle, or already IDLE after a timeout
    if (!timed_out) begin
      start_mult = rnd(noise);
      start_div  = rnd(noise);
      mult_stop  = 1'b0;
      div_stop   = 1'b0;
      @(negedge clk);
    end
    idle_check("busy_after_run");
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("reset_outputs", {55'd0, mult_init, div_init, hilo_sel, high_load, low_load,
                            busy, done, div_zero, timeout}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("busy_after_reset", {63'd0, busy}, 64'd0);

    // Align so the start is driven in a cycle numbered relative to c below.
    txn(1'b0, 32'd0, 33, 1'b0, 1'b0);          // MULT, stop in cycle c+34
    txn(1'b1, 32'd7, 19, 1'b0, 1'b0);          // DIV, stop in cycle c+20
    txn(1'b1, 32'd0, 1,  1'b0, 1'b0);          // divide by zero
    txn(1'b1, 32'd0, 1,  1'b0, 1'b0);          // DZ keeps hilo_sel from last init
    txn(1'b1, 32'd5, 10, 1'b1, 1'b1);          // both starts, repeat start_div, stray div_stop
    txn(1'b0, 32'd0, 1,  1'b0, 1'b0);          // minimum-length run
`ifdef MULDIV_TIMEOUT_EN
    txn(1'b0, 32'd0, TMO + 1, 1'b0, 1'b0);     // no stop in time: timeout
    txn(1'b0, 32'd0, TMO,     1'b0, 1'b0);     // stop on the last RUN cycle wins
    txn(1'b1, 32'd3, TMO + 4, 1'b0, 1'b1);
`endif

    // Reset mid-MULT_RUN: outputs clear at once, no load ever follows.
    txn_reset();

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      txn(logic'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
          int'($urandom_range(1, 12)),
          ($urandom_range(0, 4) == 0),
          logic'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("init_queue_empty", 64'(init_q.size()), 64'd0);
    check("resp_queue_empty", 64'(resp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  task automatic txn_reset();
    int c;
    c = cyc;
    start_mult = 1'b1;
    model_sel  = 1'b0;
    init_q.push_back('{c + 1, 6'b000_100});
    @(negedge clk);
    start_mult = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    reset     = 1'b0;
    mult_stop = 1'b1;
    #1;
    check("reset_mid_run", {55'd0, mult_init, div_init, hilo_sel, high_load, low_load,
                            busy, done, div_zero, timeout}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("done_after_reset", {62'd0, done, high_load}, 64'd0);
    idle_check("busy_after_reset_release");
  endtask

endmodule
